// File: rtl/axis_mt19937_sched.sv
// axis_mt19937_sched: shares one MT19937 word stream among PORTS AXI-Stream consumers.
// The block grants round-robin, fixed-length bursts and marks the final beat with tlast.
// It also runs a reseed handshake with the generator between bursts.
// The data path is combinational. Only the grant and beat count are registered.
module axis_mt19937_sched #(
  parameter int unsigned PORTS     = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // generator word stream
  input  logic [31:0]           input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  // generator seed interface
  output logic [31:0]           gen_seed_val,
  output logic                  gen_seed_start,
  input  logic                  gen_busy,
  // consumer side
  input  logic [PORTS-1:0]      port_req,
  output logic [32*PORTS-1:0]   output_axis_tdata,
  output logic [PORTS-1:0]      output_axis_tvalid,
  input  logic [PORTS-1:0]      output_axis_tready,
  output logic [PORTS-1:0]      output_axis_tlast,
  output logic [PORTS-1:0]      grant,
  // reseed control
  input  logic [31:0]           reseed_val,
  input  logic                  reseed_req,
  output logic                  reseed_ack,
  output logic                  busy
);

  localparam int unsigned PtrW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    StArb,
    StXfer,
    StSeedGo,
    StSeedHold,
    StSeedWait
  } state_e;

  state_e            state_q;
  logic [PORTS-1:0]  grant_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [CntW-1:0]   beat_cnt_q;
  logic [31:0]       seed_q;
  logic              reseed_pend_q;
  logic [31:0]       gen_seed_val_q;
  logic              gen_seed_start_q;
  logic              reseed_ack_q;

  logic              win_valid;
  logic [PtrW-1:0]   win_idx;
  logic              handshake;

  // Round-robin pick: first requesting port strictly after the last winner, with wrap.
  always_comb begin : arb_pick
    int unsigned cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 1; off <= PORTS; off++) begin
      cand = (32'(rr_ptr_q) + off) % PORTS;
      if (!win_valid && port_req[PtrW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = PtrW'(cand);
      end
    end
  end

  // Zero-latency data path: broadcast data, steer valid/ready through the grant.
  // The grant is only non-zero in StXfer, so it alone gates the handshake.
  always_comb begin
    output_axis_tdata  = {PORTS{input_axis_tdata}};
    output_axis_tvalid = grant_q & {PORTS{input_axis_tvalid}};
    output_axis_tlast  = (beat_cnt_q == LastBeat) ? grant_q : '0;
    input_axis_tready  = |(grant_q & output_axis_tready);
    handshake          = input_axis_tvalid & input_axis_tready;
  end

  // Scheduler FSM with registered grant, seed and ack outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StArb;
      grant_q          <= '0;
      rr_ptr_q         <= PtrW'(PORTS - 1);
      beat_cnt_q       <= '0;
      seed_q           <= '0;
      reseed_pend_q    <= 1'b0;
      gen_seed_val_q   <= '0;
      gen_seed_start_q <= 1'b0;
      reseed_ack_q     <= 1'b0;
    end else begin
      gen_seed_start_q <= 1'b0;
      reseed_ack_q     <= 1'b0;

      // A later request overwrites the seed; only one reseed runs per pending period.
      if (reseed_req) begin
        seed_q        <= reseed_val;
        reseed_pend_q <= 1'b1;
      end

      unique case (state_q)
        StArb: begin
          if (reseed_pend_q) begin
            // Seed goes out now. Pending is cleared here so a request that arrives
            // in this same cycle is held for the next ARB rather than lost.
            gen_seed_val_q   <= seed_q;
            gen_seed_start_q <= 1'b1;
            if (!reseed_req) begin
              reseed_pend_q <= 1'b0;
            end
            state_q <= StSeedGo;
          end else if (win_valid) begin
            grant_q    <= {{(PORTS-1){1'b0}}, 1'b1} << win_idx;
            rr_ptr_q   <= win_idx;
            beat_cnt_q <= '0;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          if (handshake) begin
            if (beat_cnt_q == LastBeat) begin
              grant_q    <= '0;
              beat_cnt_q <= '0;
              state_q    <= StArb;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StSeedGo: begin
          state_q <= StSeedHold;
        end
        // The generator raises busy a cycle late; skip one cycle before sampling it.
        StSeedHold: begin
          state_q <= StSeedWait;
        end
        StSeedWait: begin
          if (!gen_busy) begin
            reseed_ack_q <= 1'b1;
            state_q      <= StArb;
          end
        end
        default: begin
          state_q <= StArb;
        end
      endcase
    end
  end

  // Registered outputs.
  always_comb begin
    grant          = grant_q;
    gen_seed_val   = gen_seed_val_q;
    gen_seed_start = gen_seed_start_q;
    reseed_ack     = reseed_ack_q;
    busy           = (state_q != StArb);
  end

  // Grant is one-hot or empty, and no word is taken outside a burst.
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q != StXfer) |-> !input_axis_tready);

endmodule

// File: tb/tb_axis_mt19937_sched.sv
// Directed self-checking bench for axis_mt19937_sched (PORTS=4, BURST_LEN=8).
// Inputs change on the falling edge, and outputs are sampled 1ns later.
module tb_axis_mt19937_sched;

  localparam int unsigned PORTS     = 4;
  localparam int unsigned BURST_LEN = 8;

  logic                clk;
  logic                rst_n;
  logic [31:0]         input_axis_tdata;
  logic                input_axis_tvalid;
  logic                input_axis_tready;
  logic [31:0]         gen_seed_val;
  logic                gen_seed_start;
  logic                gen_busy;
  logic [PORTS-1:0]    port_req;
  logic [32*PORTS-1:0] output_axis_tdata;
  logic [PORTS-1:0]    output_axis_tvalid;
  logic [PORTS-1:0]    output_axis_tready;
  logic [PORTS-1:0]    output_axis_tlast;
  logic [PORTS-1:0]    grant;
  logic [31:0]         reseed_val;
  logic                reseed_req;
  logic                reseed_ack;
  logic                busy;

  int total;
  int bad;

  axis_mt19937_sched #(
    .PORTS     (PORTS),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .gen_seed_val       (gen_seed_val),
    .gen_seed_start     (gen_seed_start),
    .gen_busy           (gen_busy),
    .port_req           (port_req),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .grant              (grant),
    .reseed_val         (reseed_val),
    .reseed_req         (reseed_req),
    .reseed_ack         (reseed_ack),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; port_req = '0; reseed_req = 1'b0; gen_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (output_axis_tvalid !== 4'b0000) begin bad++; $display("FAIL reset_tvalid got=%b exp=0000", output_axis_tvalid); end
    total++; if (output_axis_tlast !== 4'b0000) begin bad++; $display("FAIL reset_tlast got=%b exp=0000", output_axis_tlast); end
    total++; if (input_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", input_axis_tready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (gen_seed_start !== 1'b0) begin bad++; $display("FAIL reset_seed_start got=%b exp=0", gen_seed_start); end
    total++; if (gen_seed_val !== 32'd0) begin bad++; $display("FAIL reset_seed_val got=%h exp=0", gen_seed_val); end
    total++; if (reseed_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", reseed_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b/%b exp=0000/0", grant, busy); end
  endtask

  task automatic test_single_port();
    logic [3:0] exp_last;
    @(negedge clk);
    output_axis_tready = 4'b1111; input_axis_tvalid = 1'b1; port_req = 4'b0001;
    input_axis_tdata = 32'hA000_0000;
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL sp_grant_early got=%b exp=0000", grant); end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      input_axis_tdata = 32'hA000_0000 + b;
      if (b == 7) port_req = 4'b0000;
      #1;
      exp_last = (b == 7) ? 4'b0001 : 4'b0000;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL sp_grant b=%0d got=%b exp=0001", b, grant); end
      total++; if (output_axis_tvalid !== 4'b0001) begin bad++; $display("FAIL sp_tvalid b=%0d got=%b exp=0001", b, output_axis_tvalid); end
      total++; if (output_axis_tlast !== exp_last) begin bad++; $display("FAIL sp_tlast b=%0d got=%b exp=%b", b, output_axis_tlast, exp_last); end
      total++; if (input_axis_tready !== 1'b1) begin bad++; $display("FAIL sp_tready b=%0d got=%b exp=1", b, input_axis_tready); end
      total++; if (output_axis_tdata[31:0] !== 32'hA000_0000 + b) begin bad++; $display("FAIL sp_data0 b=%0d got=%h exp=%h", b, output_axis_tdata[31:0], 32'hA000_0000 + b); end
      total++; if (output_axis_tdata[127:96] !== 32'hA000_0000 + b) begin bad++; $display("FAIL sp_data3 b=%0d got=%h exp=%h", b, output_axis_tdata[127:96], 32'hA000_0000 + b); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sp_busy b=%0d got=%b exp=1", b, busy); end
    end
    @(negedge clk); #1;
    total++; if (grant !== 4'b0000 || output_axis_tvalid !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL sp_idle got=%b/%b/%b exp=0000/0000/0", grant, output_axis_tvalid, busy);
    end
    total++; if (input_axis_tready !== 1'b0) begin bad++; $display("FAIL sp_idle_tready got=%b exp=0", input_axis_tready); end
  endtask

  task automatic test_round_robin();
    int order [5];
    logic [3:0] exp_g;
    logic [3:0] exp_last;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    @(negedge clk);
    port_req = 4'b1111; output_axis_tready = 4'b1111; input_axis_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << order[k];
      for (int b = 0; b < 8; b++) begin
        @(negedge clk); #1;
        exp_last = (b == 7) ? exp_g : 4'b0000;
        total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant k=%0d b=%0d got=%b exp=%b", k, b, grant, exp_g); end
        total++; if (output_axis_tvalid !== exp_g) begin bad++; $display("FAIL rr_tvalid k=%0d b=%0d got=%b exp=%b", k, b, output_axis_tvalid, exp_g); end
        total++; if (output_axis_tlast !== exp_last) begin bad++; $display("FAIL rr_tlast k=%0d b=%0d got=%b exp=%b", k, b, output_axis_tlast, exp_last); end
      end
      @(negedge clk);
      if (k == 4) port_req = 4'b0000;
      #1;
      total++; if (grant !== 4'b0000 || output_axis_tvalid !== 4'b0000) begin
        bad++; $display("FAIL rr_gap k=%0d got=%b/%b exp=0000/0000", k, grant, output_axis_tvalid);
      end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    logic exp_rdy;
    logic [3:0] exp_last;
    hs = 0;
    @(negedge clk);
    port_req = 4'b0100; output_axis_tready = 4'b1111; input_axis_tvalid = 1'b1;
    for (int i = 0; i < 40 && hs < 8; i++) begin
      @(negedge clk);
      exp_rdy = (i % 2 == 0);
      output_axis_tready = exp_rdy ? 4'b1111 : 4'b1011;
      input_axis_tdata = 32'hC000_0000 + hs;
      if (i == 0) port_req = 4'b0000;
      #1;
      exp_last = (hs == 7) ? 4'b0100 : 4'b0000;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL bp_grant i=%0d got=%b exp=0100", i, grant); end
      total++; if (input_axis_tready !== exp_rdy) begin bad++; $display("FAIL bp_tready i=%0d got=%b exp=%b", i, input_axis_tready, exp_rdy); end
      total++; if (output_axis_tlast !== exp_last) begin bad++; $display("FAIL bp_tlast i=%0d got=%b exp=%b", i, output_axis_tlast, exp_last); end
      total++; if (output_axis_tdata[95:64] !== 32'hC000_0000 + hs) begin bad++; $display("FAIL bp_data i=%0d got=%h exp=%h", i, output_axis_tdata[95:64], 32'hC000_0000 + hs); end
      if (exp_rdy) hs++;
    end
    output_axis_tready = 4'b1111;
    @(negedge clk); #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL bp_end got=%b exp=0000", grant); end
  endtask

  task automatic test_reseed();
    logic [3:0] exp_last;
    @(negedge clk);
    port_req = 4'b0001; output_axis_tready = 4'b1111; input_axis_tvalid = 1'b1; gen_busy = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      reseed_req = (b == 3);
      reseed_val = (b == 3) ? 32'd5489 : 32'hDEAD_BEEF;
      #1;
      exp_last = (b == 7) ? 4'b0001 : 4'b0000;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rs_grant b=%0d got=%b exp=0001", b, grant); end
      total++; if (output_axis_tlast !== exp_last) begin bad++; $display("FAIL rs_tlast b=%0d got=%b exp=%b", b, output_axis_tlast, exp_last); end
      total++; if (gen_seed_start !== 1'b0) begin bad++; $display("FAIL rs_early_start b=%0d got=%b exp=0", b, gen_seed_start); end
    end
    @(negedge clk);
    reseed_req = 1'b0;
    #1;
    total++; if (grant !== 4'b0000 || busy !== 1'b0 || gen_seed_start !== 1'b0) begin
      bad++; $display("FAIL rs_arb got=%b/%b/%b exp=0000/0/0", grant, busy, gen_seed_start);
    end
    @(negedge clk); #1;
    total++; if (gen_seed_start !== 1'b1) begin bad++; $display("FAIL rs_start got=%b exp=1", gen_seed_start); end
    total++; if (gen_seed_val !== 32'd5489) begin bad++; $display("FAIL rs_val got=%0d exp=5489", gen_seed_val); end
    total++; if (grant !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL rs_go got=%b/%b exp=0000/1", grant, busy); end
    @(negedge clk);
    gen_busy = 1'b1;
    #1;
    total++; if (gen_seed_start !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL rs_hold got=%b/%b exp=0/0000", gen_seed_start, grant); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      total++; if (grant !== 4'b0000 || reseed_ack !== 1'b0 || gen_seed_start !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL rs_wait i=%0d got=%b/%b/%b/%b exp=0000/0/0/1", i, grant, reseed_ack, gen_seed_start, busy);
      end
    end
    @(negedge clk);
    gen_busy = 1'b0;
    #1;
    total++; if (reseed_ack !== 1'b0) begin bad++; $display("FAIL rs_ack_early got=%b exp=0", reseed_ack); end
    @(negedge clk); #1;
    total++; if (reseed_ack !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL rs_ack got=%b/%b/%b exp=1/0000/0", reseed_ack, grant, busy);
    end
    @(negedge clk);
    port_req = 4'b0000;
    #1;
    total++; if (reseed_ack !== 1'b0 || grant !== 4'b0001) begin bad++; $display("FAIL rs_after got=%b/%b exp=0/0001", reseed_ack, grant); end
    repeat (8) @(negedge clk);
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rs_drain got=%b exp=0000", grant); end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] exp_last;
    @(negedge clk);
    port_req = 4'b0010; output_axis_tready = 4'b1111; input_axis_tvalid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk); #1;
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rm_grant b=%0d got=%b exp=0010", b, grant); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rm_async_grant got=%b exp=0000", grant); end
    total++; if (output_axis_tvalid !== 4'b0000 || output_axis_tlast !== 4'b0000) begin
      bad++; $display("FAIL rm_async_vl got=%b/%b exp=0000/0000", output_axis_tvalid, output_axis_tlast);
    end
    total++; if (busy !== 1'b0 || input_axis_tready !== 1'b0) begin bad++; $display("FAIL rm_async_busy got=%b/%b exp=0/0", busy, input_axis_tready); end
    @(negedge clk);
    rst_n = 1'b1; port_req = 4'b0010;
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rm_release got=%b exp=0000", grant); end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      input_axis_tdata = 32'hB000_0000 + b;
      if (b == 0) port_req = 4'b0000;
      #1;
      exp_last = (b == 7) ? 4'b0010 : 4'b0000;
      total++; if (grant !== 4'b0010 || output_axis_tvalid !== 4'b0010) begin
        bad++; $display("FAIL rm_burst b=%0d got=%b/%b exp=0010/0010", b, grant, output_axis_tvalid);
      end
      total++; if (output_axis_tlast !== exp_last) begin bad++; $display("FAIL rm_tlast b=%0d got=%b exp=%b", b, output_axis_tlast, exp_last); end
      total++; if (output_axis_tdata[63:32] !== 32'hB000_0000 + b) begin bad++; $display("FAIL rm_data b=%0d got=%h exp=%h", b, output_axis_tdata[63:32], 32'hB000_0000 + b); end
    end
    @(negedge clk); #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rm_end got=%b exp=0000", grant); end
  endtask

  task automatic test_double_reseed();
    int pulses;
    int acks;
    logic [31:0] seen_val;
    pulses = 0; acks = 0; seen_val = '0;
    @(negedge clk);
    port_req = 4'b0001; gen_busy = 1'b0; output_axis_tready = 4'b1111; input_axis_tvalid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      reseed_req = (b == 1) || (b == 3);
      reseed_val = (b == 1) ? 32'd1 : ((b == 3) ? 32'd2 : 32'hFFFF_FFFF);
      if (b == 0) port_req = 4'b0000;
      #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL dr_grant b=%0d got=%b exp=0001", b, grant); end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      reseed_req = 1'b0;
      #1;
      if (gen_seed_start === 1'b1) begin pulses++; seen_val = gen_seed_val; end
      if (reseed_ack === 1'b1) acks++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL dr_pulses got=%0d exp=1", pulses); end
    total++; if (seen_val !== 32'd2) begin bad++; $display("FAIL dr_val got=%0d exp=2", seen_val); end
    total++; if (acks != 1) begin bad++; $display("FAIL dr_acks got=%0d exp=1", acks); end
    total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL dr_idle got=%b/%b exp=0000/0", grant, busy); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1;
    input_axis_tdata = '0; input_axis_tvalid = 1'b0; gen_busy = 1'b0;
    port_req = '0; output_axis_tready = '0; reseed_val = '0; reseed_req = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_reseed();
    test_reset_mid_burst();
    test_double_reseed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
